// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared encodings for the data-memory arbiter.
// FSM states, port indices and default bus widths.
package dmem_arbiter_pkg;

  localparam int ARB_ADDR_W = 10;
  localparam int ARB_DATA_W = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ACC  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  function automatic logic [1:0] port_mask(
    input logic p
  );
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-request round-robin picker.
// Contended requests go to the port not served last.
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic       grant,
  output logic       valid
);

  logic [1:0] elig;

  assign elig  = req & mask;
  assign valid = |elig;

  // pick the eligible port, alternating on contention
  always_comb begin
    grant = PORT0;
    unique case (1'b1)
      (elig == 2'b11): grant = ~last;
      (elig == 2'b10): grant = PORT1;
      default:         grant = PORT0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between core (0) and loader (1).
// Optional atomic bursts via the DMEM_ARB_LOCK_EN macro.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH     = ARB_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_Req0,
  input  logic                      i_Req1,
  input  logic [MEM_ADDR_WIDTH-1:0] i_Addr0,
  input  logic [MEM_ADDR_WIDTH-1:0] i_Addr1,
  input  logic [DATA_WIDTH-1:0]     i_WData0,
  input  logic [DATA_WIDTH-1:0]     i_WData1,
  input  logic                      i_WrEn0,
  input  logic                      i_WrEn1,
  output logic                      o_Ack0,
  output logic                      o_Ack1,
  output logic [DATA_WIDTH-1:0]     o_RData,
  output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
  output logic [DATA_WIDTH-1:0]     o_MemDataIn,
  output logic                      o_MemWrEn,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                      i_Lock0,
  input  logic                      i_Lock1,
`endif
  input  logic [DATA_WIDTH-1:0]     i_MemDataOut
);

  arb_state_t                r_State;
  logic                      r_Owner;
  logic                      r_Last;
  logic                      r_WrEn;
  logic [MEM_ADDR_WIDTH-1:0] r_Addr;
  logic [DATA_WIDTH-1:0]     r_WData;
  logic [DATA_WIDTH-1:0]     r_RData;
  logic                      r_Ack0;
  logic                      r_Ack1;

  logic       pick_grant;
  logic       pick_valid;
  logic [1:0] pick_mask;

`ifdef DMEM_ARB_LOCK_EN
  logic r_Locked;
  logic owner_lock;

  assign owner_lock = r_Owner ? i_Lock1 : i_Lock0;
  assign pick_mask  = (r_Locked && owner_lock)
                    ? port_mask(r_Owner)
                    : 2'b11;

  // lock is armed in RESP and released in the first unlocked IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_Locked <= 1'b0;
    end else if (r_State == ARB_RESP && owner_lock) begin
      r_Locked <= 1'b1;
    end else if (r_State == ARB_IDLE && !owner_lock) begin
      r_Locked <= 1'b0;
    end
  end
`else
  assign pick_mask = 2'b11;
`endif

  rr_pick2 u_pick (
    .req   ({i_Req1, i_Req0}),
    .last  (r_Last),
    .mask  (pick_mask),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // grant / access / respond sequencer with registered payload and acks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_State <= ARB_IDLE;
      r_Owner <= PORT0;
      r_Last  <= PORT1;
      r_WrEn  <= 1'b0;
      r_Addr  <= '0;
      r_WData <= '0;
      r_RData <= '0;
      r_Ack0  <= 1'b0;
      r_Ack1  <= 1'b0;
    end else begin
      r_Ack0 <= 1'b0;
      r_Ack1 <= 1'b0;
      unique case (r_State)
        ARB_IDLE: begin
          if (pick_valid) begin
            r_Owner <= pick_grant;
            r_Addr  <= pick_grant ? i_Addr1 : i_Addr0;
            r_WData <= pick_grant ? i_WData1 : i_WData0;
            r_WrEn  <= pick_grant ? i_WrEn1 : i_WrEn0;
            r_State <= ARB_ACC;
          end
        end
        ARB_ACC: begin
          r_RData <= i_MemDataOut;
          r_Last  <= r_Owner;
          r_Ack0  <= (r_Owner == PORT0);
          r_Ack1  <= (r_Owner == PORT1);
          r_State <= ARB_RESP;
        end
        ARB_RESP: begin
          r_State <= ARB_IDLE;
        end
        default: begin
          r_State <= ARB_IDLE;
        end
      endcase
    end
  end

  assign o_MemAddr   = r_Addr;
  assign o_MemDataIn = r_WData;
  assign o_MemWrEn   = (r_State == ARB_ACC) && r_WrEn && !reset;
  assign o_RData     = r_RData;
  assign o_Ack0      = r_Ack0;
  assign o_Ack1      = r_Ack1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus random traffic against a
// transaction-level scoreboard of the two-port memory arbiter.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            issue;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_Req0, i_Req1;
  logic [AW-1:0] i_Addr0, i_Addr1;
  logic [DW-1:0] i_WData0, i_WData1;
  logic          i_WrEn0, i_WrEn1;
  logic          o_Ack0, o_Ack1;
  logic [DW-1:0] o_RData;
  logic [AW-1:0] o_MemAddr;
  logic [DW-1:0] o_MemDataIn;
  logic          o_MemWrEn;
  logic [DW-1:0] i_MemDataOut;
`ifdef DMEM_ARB_LOCK_EN
  logic          i_Lock0 = 1'b0;
  logic          i_Lock1 = 1'b0;
`endif

  dmem_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_Req0       (i_Req0),
    .i_Req1       (i_Req1),
    .i_Addr0      (i_Addr0),
    .i_Addr1      (i_Addr1),
    .i_WData0     (i_WData0),
    .i_WData1     (i_WData1),
    .i_WrEn0      (i_WrEn0),
    .i_WrEn1      (i_WrEn1),
    .o_Ack0       (o_Ack0),
    .o_Ack1       (o_Ack1),
    .o_RData      (o_RData),
    .o_MemAddr    (o_MemAddr),
    .o_MemDataIn  (o_MemDataIn),
    .o_MemWrEn    (o_MemWrEn),
`ifdef DMEM_ARB_LOCK_EN
    .i_Lock0      (i_Lock0),
    .i_Lock1      (i_Lock1),
`endif
    .i_MemDataOut (i_MemDataOut)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit init_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] initval(input int a);
    if (a == 5) return 32'hDEADBEEF;
    if (a == 3) return 32'h0000_3333;
    return {16'hC0DE, 16'(a)};
  endfunction

  // memory the arbiter talks to: combinational read, clocked write
  logic [DW-1:0] mem [256];
  assign i_MemDataOut = mem[o_MemAddr];
  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= initval(i);
    end else if (o_MemWrEn) begin
      mem[o_MemAddr] <= o_MemDataIn;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  // reference model state
  txn_t q0[$];
  txn_t q1[$];
  logic [DW-1:0] refm [int];
  int mlast = 1;
  int lastack = -10;
  int locked = -1;
  int wr_seen = 0;
  int wr_acked = 0;
  logic          pv_we;
  logic [AW-1:0] pv_addr;
  logic [DW-1:0] pv_din;
`ifdef DMEM_ARB_LOCK_EN
  bit lk0h [int];
  bit lk1h [int];
`endif

  function automatic logic [DW-1:0] refrd(input logic [AW-1:0] a);
    if (refm.exists(int'(a))) return refm[int'(a)];
    return initval(int'(a));
  endfunction

  // monitor: every ack is matched against the oldest request of that port
  always @(negedge clk) begin
    txn_t t;
    int p, g, exp_p, g0;
    bit oth;
`ifdef DMEM_ARB_LOCK_EN
    lk0h[cyc] = i_Lock0;
    lk1h[cyc] = i_Lock1;
`endif
    if (reset) begin
      q0.delete();
      q1.delete();
      mlast = 1;
      lastack = cyc;
      locked = -1;
    end else begin
      if (o_MemWrEn) wr_seen++;
      if (o_Ack0 || o_Ack1) begin
        chk("dual_ack", {63'd0, o_Ack0 & o_Ack1}, 64'd0);
        p = o_Ack1 ? 1 : 0;
        g = cyc - 2;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
          chk("ack_no_req", 64'd1, 64'd0);
        end else begin
          if (p == 0) begin
            t = q0.pop_front();
            oth = q1.size() > 0 && q1[0].issue <= g;
          end else begin
            t = q1.pop_front();
            oth = q0.size() > 0 && q0[0].issue <= g;
          end
          g0 = (t.issue > lastack + 1) ? t.issue : lastack + 1;
          chk("grant_cycle", 64'(g), 64'(g0));
`ifdef DMEM_ARB_LOCK_EN
          if (locked >= 0 && !(locked == 0 ? lk0h[g] : lk1h[g]))
            locked = -1;
`endif
          exp_p = (locked >= 0) ? locked : 1 - mlast;
          if (oth || locked >= 0) chk("grant_port", 64'(p), 64'(exp_p));
          chk("rdata", {32'd0, o_RData}, {32'd0, refrd(t.addr)});
          chk("acc_we", {63'd0, pv_we}, {63'd0, t.we});
          chk("acc_addr", {56'd0, pv_addr}, {56'd0, t.addr});
          if (t.we) begin
            chk("acc_wdata", {32'd0, pv_din}, {32'd0, t.wd});
            refm[int'(t.addr)] = t.wd;
            wr_acked++;
          end
          mlast = p;
          lastack = cyc;
`ifdef DMEM_ARB_LOCK_EN
          if (p == 0 ? i_Lock0 : i_Lock1) locked = p;
`endif
        end
      end
    end
    pv_we = o_MemWrEn;
    pv_addr = o_MemAddr;
    pv_din = o_MemDataIn;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int p, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.wd = d;
    t.issue = cyc;
    if (p == 0) begin
      i_Req0 = 1'b1; i_WrEn0 = we; i_Addr0 = a; i_WData0 = d;
      q0.push_back(t);
    end else begin
      i_Req1 = 1'b1; i_WrEn1 = we; i_Addr1 = a; i_WData1 = d;
      q1.push_back(t);
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) i_Req0 = 1'b0;
    else i_Req1 = 1'b0;
  endtask

  task automatic wait_ack(input int p, output int when);
    bit got = 1'b0;
    when = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = (p == 0) ? o_Ack0 : o_Ack1;
      if (got) when = cyc;
    end
    chk("ack_timeout", {63'd0, got}, 64'd1);
    tick();
  endtask

  task automatic drive_rand(input int p);
    int gap, w;
    for (int n = 0; n < 40; n++) begin
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        drop(p);
        repeat (gap) tick();
      end
      issue(p, 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)), $urandom);
      wait_ack(p, w);
    end
    drop(p);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, w0, n, prev, p;
    bit got;
    int ord [4];
    ord = '{0, 1, 0, 1};
    reset = 1'b1;
    i_Req0 = 0; i_Req1 = 0; i_WrEn0 = 0; i_WrEn1 = 0;
    i_Addr0 = 0; i_Addr1 = 0; i_WData0 = 0; i_WData1 = 0;
    init_en = 1'b1;
    tick();
    init_en = 1'b0;
    repeat (2) tick();

    // reset values
    @(negedge clk);
    chk("rst_ack0", {63'd0, o_Ack0}, 64'd0);
    chk("rst_ack1", {63'd0, o_Ack1}, 64'd0);
    chk("rst_rdata", {32'd0, o_RData}, 64'd0);
    chk("rst_maddr", {56'd0, o_MemAddr}, 64'd0);
    chk("rst_mdin", {32'd0, o_MemDataIn}, 64'd0);
    chk("rst_mwe", {63'd0, o_MemWrEn}, 64'd0);

    // reset during the ACC cycle of a write
    tick();
    reset = 1'b0;
    issue(0, 1'b1, 8'd3, 32'hAAAA0000);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_mwe", {63'd0, o_MemWrEn}, 64'd0);
    tick();
    reset = 1'b0;
    drop(0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_rst_ack", {62'd0, o_Ack1, o_Ack0}, 64'd0);
      chk("mid_rst_maddr", {56'd0, o_MemAddr}, 64'd0);
      chk("mid_rst_mdin", {32'd0, o_MemDataIn}, 64'd0);
      chk("mid_rst_rdata", {32'd0, o_RData}, 64'd0);
      chk("mid_rst_mwe", {63'd0, o_MemWrEn}, 64'd0);
    end
    chk("mid_rst_mem3", {32'd0, mem[3]}, {32'd0, initval(3)});

    // single read of address 5
    tick();
    issue(0, 1'b0, 8'd5, 32'd0);
    tick();
    @(negedge clk);
    chk("rd_maddr", {56'd0, o_MemAddr}, 64'd5);
    chk("rd_mwe", {63'd0, o_MemWrEn}, 64'd0);
    tick();
    @(negedge clk);
    chk("rd_ack0", {63'd0, o_Ack0}, 64'd1);
    chk("rd_data", {32'd0, o_RData}, 64'hDEADBEEF);
    tick();
    drop(0);

    // port 1 write then read back
    tick();
    w0 = wr_seen;
    issue(1, 1'b1, 8'd9, 32'h12345678);
    wait_ack(1, a);
    chk("wr_once", 64'(wr_seen - w0), 64'd1);
    issue(1, 1'b0, 8'd9, 32'd0);
    wait_ack(1, a);
    chk("rd_after_wr", {32'd0, o_RData}, 64'h12345678);
    drop(1);

    // both ports held continuously
    tick();
    issue(0, 1'b0, 8'd1, 32'd0);
    issue(1, 1'b0, 8'd2, 32'd0);
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int j = 0; j < 20 && !got; j++) begin
        @(negedge clk);
        got = o_Ack0 | o_Ack1;
      end
      chk("cont_ack", {63'd0, got}, 64'd1);
      p = o_Ack1 ? 1 : 0;
      chk("cont_order", 64'(p), 64'(ord[k]));
      if (k > 0) chk("cont_gap", 64'(cyc - prev), 64'd3);
      prev = cyc;
      tick();
      if (k < 3) issue(p, 1'b0, 8'($urandom_range(0, 15)), 32'd0);
      else drop(p);
    end
    wait_ack(0, a);
    drop(0);

    // request held one cycle past ack is one more access
    tick();
    issue(0, 1'b0, 8'd5, 32'd0);
    wait_ack(0, a);
    issue(0, 1'b0, 8'd5, 32'd0);
    tick();
    drop(0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_Ack0) n++;
    end
    chk("hold_extra", 64'(n), 64'd1);

`ifdef DMEM_ARB_LOCK_EN
    // port 0 locks three accesses while port 1 waits
    tick();
    i_Lock0 = 1'b1;
    issue(0, 1'b0, 8'd20, 32'd0);
    tick();
    issue(1, 1'b0, 8'd21, 32'd0);
    for (int k = 0; k < 3; k++) begin
      wait_ack(0, a);
      if (k < 2) issue(0, 1'b1, 8'(22 + k), $urandom);
    end
    drop(0);
    i_Lock0 = 1'b0;
    wait_ack(1, b);
    chk("lock_release", 64'(b - a), 64'd3);
    drop(1);
`endif

    // randomized two-port traffic
    tick();
    fork
      drive_rand(0);
      drive_rand(1);
    join
    repeat (6) tick();
    chk("q_empty", 64'(q0.size() + q1.size()), 64'd0);
    chk("wr_count", 64'(wr_seen), 64'(wr_acked));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
